// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and the hazard controller (slave).
// Includes the controller's FSM state as a debug observation point.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_addr_i;
    logic [4:0]       id_rt_addr_i;
    logic             id_rs_used_i;
    logic             id_rt_used_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_branch_taken_i;
    logic             mem_access_i;
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_stall_o;
    logic             idex_bubble_o;
    logic             exmem_stall_o;
    logic             memwb_bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             dbg_state;

    modport master (
        output id_rs_addr_i, id_rt_addr_i, id_rs_used_i, id_rt_used_i,
               ex_memread_i, ex_rd_addr_i, ex_branch_taken_i, mem_access_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
               idex_bubble_o, exmem_stall_o, memwb_bubble_o,
               stall_cnt_o, flush_cnt_o, dbg_state
    );

    modport slave (
        input  id_rs_addr_i, id_rt_addr_i, id_rs_used_i, id_rt_used_i,
               ex_memread_i, ex_rd_addr_i, ex_branch_taken_i, mem_access_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
               idex_bubble_o, exmem_stall_o, memwb_bubble_o,
               stall_cnt_o, flush_cnt_o, dbg_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze > taken-branch flush > load-use stall.
// Controls are combinational; FSM state and saturating perf counters are registered.
module hazard_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  hz
);
    // A zero-width counter is illegal, so MEM_WAIT=0 still keeps one bit.
    localparam int WCNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = (MEM_WAIT > 0) ? WCNT_W'(MEM_WAIT - 1) : '0;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_stall, flush, load_use, rs_hit, rt_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (hz.pc_stall_o && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (hz.ifid_flush_o && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_stall = 1'b0;
        if (MEM_WAIT > 0) begin
            case (state_q)
                RUN: begin
                    if (hz.mem_access_i) begin
                        mem_stall = 1'b1;
                        state_d   = MWAIT;
                        wcnt_d    = WCNT_INIT;
                    end
                end
                MWAIT: begin
                    // wcnt=0 is the release cycle; the same access must not re-arm.
                    if (wcnt_q != '0) begin
                        mem_stall = 1'b1;
                        wcnt_d    = wcnt_q - 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        rs_hit   = hz.id_rs_used_i && (hz.ex_rd_addr_i == hz.id_rs_addr_i);
        rt_hit   = hz.id_rt_used_i && (hz.ex_rd_addr_i == hz.id_rt_addr_i);
        flush    = !mem_stall && hz.ex_branch_taken_i;
        load_use = !mem_stall && !hz.ex_branch_taken_i && hz.ex_memread_i &&
                   (hz.ex_rd_addr_i != 5'd0) && (rs_hit || rt_hit);

        hz.pc_stall_o     = 1'b0;
        hz.ifid_stall_o   = 1'b0;
        hz.ifid_flush_o   = 1'b0;
        hz.idex_stall_o   = 1'b0;
        hz.idex_bubble_o  = 1'b0;
        hz.exmem_stall_o  = 1'b0;
        hz.memwb_bubble_o = 1'b0;
        if (rst_i) begin
            if (mem_stall) begin
                hz.pc_stall_o     = 1'b1;
                hz.ifid_stall_o   = 1'b1;
                hz.idex_stall_o   = 1'b1;
                hz.exmem_stall_o  = 1'b1;
                hz.memwb_bubble_o = 1'b1;
            end else if (flush) begin
                hz.ifid_flush_o  = 1'b1;
                hz.idex_bubble_o = 1'b1;
            end else if (load_use) begin
                hz.pc_stall_o    = 1'b1;
                hz.ifid_stall_o  = 1'b1;
                hz.idex_bubble_o = 1'b1;
            end
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
    assign hz.dbg_state   = state_q;
endmodule
